// File: rtl/ppc_pkg.sv
// Shared types and constants for the PPC fetch slice.
// Contents: width constants, fetch FSM state encoding, queue entry type,
//           and the next-doubleword PC helper.
package ppc_pkg;

  localparam int XLEN   = 64;  // PC / data width
  localparam int ILEN   = 32;  // instruction width
  localparam int DWADDR = 61;  // doubleword address width (PC bits [0:60])

  typedef enum logic {
    FETCH = 1'b0,
    WAIT  = 1'b1
  } fetch_state_t;

  // One buffered instruction together with the address it was fetched from.
  typedef struct packed {
    logic [0:ILEN-1] inst;
    logic [0:XLEN-1] pc;
  } fetch_entry_t;

  // Start of the doubleword following the one containing pc.
  function automatic logic [0:XLEN-1] next_dw(input logic [0:XLEN-1] pc);
    return {pc[0:DWADDR-1] + DWADDR'(1), 3'b000};
  endfunction

endpackage

// File: rtl/ppc_fetch_if.sv
// Bundles the fetch unit's core-facing and memory-facing signals.
// master: the fetch unit (drives read strobe/address and the instruction head).
// slave:  core + memory side (drives redirect, read data and inst_ready).
interface ppc_fetch_if;
  import ppc_pkg::*;

  logic                redirect_valid;
  logic [0:XLEN-1]     redirect_pc;
  logic                mem_read_en;
  logic [0:DWADDR-1]   mem_read_addr;
  logic [0:XLEN-1]     mem_read_data;
  logic                inst_valid;
  logic                inst_ready;
  logic [0:ILEN-1]     inst;
  logic [0:XLEN-1]     inst_pc;

  modport master (
    input  redirect_valid, redirect_pc, mem_read_data, inst_ready,
    output mem_read_en, mem_read_addr, inst_valid, inst, inst_pc
  );

  modport slave (
    output redirect_valid, redirect_pc, mem_read_data, inst_ready,
    input  mem_read_en, mem_read_addr, inst_valid, inst, inst_pc
  );
endinterface

// File: rtl/ppc_fetch_queue.sv
// Circular instruction queue: 0/1/2-wide push, 1-wide pop, synchronous flush.
// Ports: clk, reset (async, active-high), flush, push_cnt/push0/push1, pop,
//        head (entry at read pointer), count (occupancy 0..DEPTH).
module ppc_fetch_queue
  import ppc_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         flush,
  input  logic [1:0]                   push_cnt,
  input  fetch_entry_t                 push0,
  input  fetch_entry_t                 push1,
  input  logic                         pop,
  output fetch_entry_t                 head,
  output logic [$clog2(DEPTH):0]       count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  fetch_entry_t    store [DEPTH];
  logic [PW-1:0]   rd_ptr;
  logic [PW-1:0]   wr_ptr;

  assign head = store[rd_ptr];

  // Pointers are PW bits wide and DEPTH is a power of two, so natural
  // overflow gives the modulo-DEPTH wrap.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (pop)
        rd_ptr <= rd_ptr + PW'(1);
      wr_ptr <= wr_ptr + PW'(push_cnt);
      count  <= count + CW'(push_cnt) - CW'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (!flush) begin
      if (push_cnt != 2'd0)
        store[wr_ptr] <= push0;
      if (push_cnt == 2'd2)
        store[wr_ptr + PW'(1)] <= push1;
    end
  end

endmodule

// File: rtl/ppc_fetch_unit.sv
// Instruction fetch stage: owns the fetch PC, reads doublewords from memory
// port #1, splits them into big-endian instructions and queues them for the core.
// Ports: clk, reset (async, active-high), bus (ppc_fetch_if.master).
// Optional `PPC_FETCH_STATS_EN adds fetch_count / flush_count outputs.
module ppc_fetch_unit
  import ppc_pkg::*;
#(
  parameter logic [0:XLEN-1] RESET_PC = '0,
  parameter int              DEPTH    = 4
) (
  input  logic            clk,
  input  logic            reset,
  ppc_fetch_if.master     bus
`ifdef PPC_FETCH_STATS_EN
  ,
  output logic [0:31]     fetch_count,
  output logic [0:31]     flush_count
`endif
);

  localparam int CW = $clog2(DEPTH) + 1;

  fetch_state_t    state_q, state_d;
  logic [0:XLEN-1] pc_q, pc_d;
  logic [CW-1:0]   count;
  logic [CW-1:0]   free;
  logic [CW-1:0]   need;
  logic            read_go;
  logic            pop;
  logic [1:0]      push_cnt;
  fetch_entry_t    push0, push1, head, hold_q;

  // Space check uses occupancy before any same-cycle pop.
  assign free = CW'(DEPTH) - count;
  assign need = pc_q[61] ? CW'(1) : CW'(2);
  assign pop  = bus.inst_valid & bus.inst_ready;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= FETCH;
      pc_q    <= {RESET_PC[0:61], 2'b00};
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    read_go    = 1'b0;
    push_cnt   = 2'd0;
    push0.inst = bus.mem_read_data[0:31];
    push0.pc   = pc_q;
    push1.inst = bus.mem_read_data[32:63];
    push1.pc   = pc_q + 64'd4;
    if (bus.redirect_valid) begin
      // Re-steer wins over everything; a WAIT response is simply not pushed.
      pc_d    = {bus.redirect_pc[0:61], 2'b00};
      state_d = FETCH;
    end else begin
      case (state_q)
        FETCH: begin
          if (free >= need) begin
            read_go = 1'b1;
            state_d = WAIT;
          end
        end
        WAIT: begin
          if (pc_q[61]) begin
            // Entered mid-doubleword: only the second word is wanted.
            push_cnt   = 2'd1;
            push0.inst = bus.mem_read_data[32:63];
          end else begin
            push_cnt = 2'd2;
          end
          pc_d    = next_dw(pc_q);
          state_d = FETCH;
        end
        default: state_d = FETCH;
      endcase
    end
  end

  ppc_fetch_queue #(.DEPTH(DEPTH)) u_queue (
    .clk      (clk),
    .reset    (reset),
    .flush    (bus.redirect_valid),
    .push_cnt (push_cnt),
    .push0    (push0),
    .push1    (push1),
    .pop      (pop),
    .head     (head),
    .count    (count)
  );

  // Remembers the last presented head so inst/inst_pc hold when the queue drains.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      hold_q <= '0;
    else if (count != '0)
      hold_q <= head;
  end

  // Gated by reset so the strobe is low while reset is held.
  assign bus.mem_read_en   = read_go & ~reset;
  assign bus.mem_read_addr = pc_q[0:DWADDR-1];
  assign bus.inst_valid    = (count != '0);
  assign bus.inst          = bus.inst_valid ? head.inst : hold_q.inst;
  assign bus.inst_pc       = bus.inst_valid ? head.pc   : hold_q.pc;

`ifdef PPC_FETCH_STATS_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fetch_count <= '0;
      flush_count <= '0;
    end else begin
      if (bus.mem_read_en)
        fetch_count <= fetch_count + 32'd1;
      if (bus.redirect_valid)
        flush_count <= flush_count + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_ppc_fetch_unit.sv
// Directed bench for ppc_fetch_unit: per-cycle vector table plus hand-written
// reset-during-read and (optional) statistics sequences.
module tb_ppc_fetch_unit;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  ppc_fetch_if bus ();

`ifdef PPC_FETCH_STATS_EN
  logic [0:31] fetch_count;
  logic [0:31] flush_count;
`endif

  ppc_fetch_unit dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
`ifdef PPC_FETCH_STATS_EN
    ,
    .fetch_count (fetch_count),
    .flush_count (flush_count)
`endif
  );

  // Memory image: word at byte address A is 0x38000001 + A/4, so
  // doubleword 0 is 0x38000001_38000002. One-cycle read latency.
  function automatic logic [63:0] dw(input logic [63:0] a);
    logic [31:0] hi;
    hi = 32'h3800_0001 + 32'(a << 1);
    return {hi, hi + 32'd1};
  endfunction

  logic [63:0] mem_q = '0;
  always @(posedge clk)
    if (bus.mem_read_en)
      mem_q <= dw(64'(bus.mem_read_addr));
  assign bus.mem_read_data = mem_q;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic chk_outs(input string tag, input logic en, input logic [63:0] addr,
                          input logic vld, input logic [31:0] ins, input logic [63:0] pc);
    chk({tag, " mem_read_en"},   64'(bus.mem_read_en), 64'(en));
    chk({tag, " mem_read_addr"}, 64'(bus.mem_read_addr), addr);
    chk({tag, " inst_valid"},    64'(bus.inst_valid), 64'(vld));
    chk({tag, " inst"},          64'(bus.inst), 64'(ins));
    chk({tag, " inst_pc"},       64'(bus.inst_pc), pc);
  endtask

  typedef struct {
    logic        rst;
    logic        rdv;
    logic [63:0] rpc;
    logic        rdy;
    logic        en;
    logic [63:0] addr;
    logic        vld;
    logic [31:0] ins;
    logic [63:0] pc;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic rst, logic rdv, logic [63:0] rpc, logic rdy,
                              logic en, logic [63:0] addr, logic vld,
                              logic [31:0] ins, logic [63:0] pc);
    vec_t v;
    v.rst = rst; v.rdv = rdv; v.rpc = rpc; v.rdy = rdy;
    v.en = en; v.addr = addr; v.vld = vld; v.ins = ins; v.pc = pc;
    return v;
  endfunction

  initial begin
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = '0;
    bus.inst_ready     = 1'b0;

    //                rst rdv rpc     rdy  en addr vld inst          pc
    // Streaming with ready held high, redirect during WAIT, redirect in FETCH.
    vecs.push_back(mk(1, 0, 64'h0,  1,   0, 0, 0, 32'h0,        64'h0));
    vecs.push_back(mk(0, 0, 64'h0,  1,   1, 0, 0, 32'h0,        64'h0));
    vecs.push_back(mk(0, 0, 64'h0,  1,   0, 0, 0, 32'h0,        64'h0));
    vecs.push_back(mk(0, 0, 64'h0,  1,   1, 1, 1, 32'h38000001, 64'h0));
    vecs.push_back(mk(0, 0, 64'h0,  1,   0, 1, 1, 32'h38000002, 64'h4));
    vecs.push_back(mk(0, 0, 64'h0,  1,   1, 2, 1, 32'h38000003, 64'h8));
    vecs.push_back(mk(0, 1, 64'h40, 1,   0, 2, 1, 32'h38000004, 64'hC));
    vecs.push_back(mk(0, 0, 64'h0,  1,   1, 8, 0, 32'h38000004, 64'hC));
    vecs.push_back(mk(0, 0, 64'h0,  1,   0, 8, 0, 32'h38000004, 64'hC));
    vecs.push_back(mk(0, 1, 64'hF,  1,   0, 9, 1, 32'h38000011, 64'h40));
    vecs.push_back(mk(0, 0, 64'h0,  1,   1, 1, 0, 32'h38000011, 64'h40));
    vecs.push_back(mk(0, 0, 64'h0,  1,   0, 1, 0, 32'h38000011, 64'h40));
    vecs.push_back(mk(0, 0, 64'h0,  1,   1, 2, 1, 32'h38000004, 64'hC));
    vecs.push_back(mk(0, 0, 64'h0,  1,   0, 2, 0, 32'h38000004, 64'hC));
    // Backpressure from reset: queue fills, reads stall until two pops.
    vecs.push_back(mk(1, 0, 64'h0,  0,   0, 0, 0, 32'h0,        64'h0));
    vecs.push_back(mk(0, 0, 64'h0,  0,   1, 0, 0, 32'h0,        64'h0));
    vecs.push_back(mk(0, 0, 64'h0,  0,   0, 0, 0, 32'h0,        64'h0));
    vecs.push_back(mk(0, 0, 64'h0,  0,   1, 1, 1, 32'h38000001, 64'h0));
    vecs.push_back(mk(0, 0, 64'h0,  0,   0, 1, 1, 32'h38000001, 64'h0));
    vecs.push_back(mk(0, 0, 64'h0,  0,   0, 2, 1, 32'h38000001, 64'h0));
    vecs.push_back(mk(0, 0, 64'h0,  1,   0, 2, 1, 32'h38000001, 64'h0));
    vecs.push_back(mk(0, 0, 64'h0,  0,   0, 2, 1, 32'h38000002, 64'h4));
    vecs.push_back(mk(0, 0, 64'h0,  1,   0, 2, 1, 32'h38000002, 64'h4));
    vecs.push_back(mk(0, 0, 64'h0,  0,   1, 2, 1, 32'h38000003, 64'h8));

    for (int i = 0; i < vecs.size(); i++) begin
      @(posedge clk); #2;
      reset              = vecs[i].rst;
      bus.redirect_valid = vecs[i].rdv;
      bus.redirect_pc    = vecs[i].rpc;
      bus.inst_ready     = vecs[i].rdy;
      #1;
      chk_outs($sformatf("row%0d", i), vecs[i].en, vecs[i].addr, vecs[i].vld,
               vecs[i].ins, vecs[i].pc);
    end

    // Reset while a read is in flight and the queue is non-empty.
    @(posedge clk); #3;
    chk_outs("inflight", 1'b0, 64'h2, 1'b1, 32'h38000003, 64'h8);
    reset = 1'b1;
    #1;
    chk_outs("rst_async", 1'b0, 64'h0, 1'b0, 32'h0, 64'h0);
    @(posedge clk); #2;
    reset = 1'b0;
    bus.inst_ready = 1'b1;
    #1;
    chk_outs("rst_rel_c0", 1'b1, 64'h0, 1'b0, 32'h0, 64'h0);
    @(posedge clk); #3;
    chk_outs("rst_rel_c1", 1'b0, 64'h0, 1'b0, 32'h0, 64'h0);
    @(posedge clk); #3;
    chk_outs("rst_rel_c2", 1'b1, 64'h1, 1'b1, 32'h38000001, 64'h0);

`ifdef PPC_FETCH_STATS_EN
    @(posedge clk); #2;
    reset = 1'b1;
    #1;
    chk("stats_rst_fetch", 64'(fetch_count), 64'd0);
    chk("stats_rst_flush", 64'(flush_count), 64'd0);
    @(posedge clk); #2;
    reset = 1'b0;
    repeat (5) @(posedge clk);
    #2;
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 64'h80;
    @(posedge clk); #2;
    bus.redirect_valid = 1'b0;
    #1;
    chk("stats_fetch_count", 64'(fetch_count), 64'd3);
    chk("stats_flush_count", 64'(flush_count), 64'd1);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
